qmult_seq: RTL and testbench

Sequential fixed-point multiplier for the same signed-magnitude (Q,N) format used by the library's sequential divider. It accepts two (Q,N) operands with a start pulse and computes one shift-add partial product per clock. It returns a truncated (Q,N) product with complete and overflow flags. It is the multiply counterpart in the math library, for datapaths that cannot afford a single-cycle array multiplier.

---
 rtl/qmult_seq_pkg.sv | 39 +++
 rtl/qmult_seq.sv | 100 ++++++++++
 tb/tb_qmult_seq.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/qmult_seq_pkg.sv
//------------------------------------------------------------------------------
// Module   : qmult_seq_pkg
// Brief    : Shared fixed-point math library definitions (FSM states, widths,
//            signed-magnitude field positions).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package qmult_seq_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int c_Q_DEF  = 15;
    localparam int c_N_DEF  = 32;
    localparam int c_CW_DEF = $clog2(c_N_DEF - 1);

    // Width of a bit counter that must hold N-2.
    function automatic int count_width(input int n);
        return $clog2(n - 1);
    endfunction

    function automatic int sign_pos(input int n);
        return n - 1;
    endfunction

    function automatic int mag_msb(input int n);
        return n - 2;
    endfunction

    function automatic int frac_msb(input int q);
        return q - 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/qmult_seq.sv
//------------------------------------------------------------------------------
// Module   : qmult_seq
// Brief    : Sequential shift-add signed-magnitude (Q,N) multiplier, one
//            partial product per clock, truncated result with overflow flag.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module qmult_seq
    import qmult_seq_pkg::*;
#(
    parameter int Q = c_Q_DEF,
    parameter int N = c_N_DEF
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [N-1:0] i_multiplicand,
    input  logic [N-1:0] i_multiplier,
    input  logic         i_start,
    output logic [N-1:0] o_result_out,
    output logic         o_complete,
    output logic         o_overflow
);

    localparam int c_CW  = count_width(N);
    localparam int c_PW  = 2 * N - 2;
    localparam int c_SB  = sign_pos(N);
    localparam int c_MSB = mag_msb(N);

    state_t            r_state;
    state_t            w_next;
    logic [c_PW-1:0]   r_mcand;
    logic [c_PW-1:0]   r_acc;
    logic [c_PW-1:0]   w_sum;
    logic [c_MSB:0]    r_mplier;
    logic [c_CW-1:0]   r_count;
    logic              r_sign;
    logic [N-1:0]      r_result;
    logic              r_overflow;
    logic              w_last;

    assign w_last = (r_count == '0);

    // The single datapath adder; on the last step its output is the full product.
    assign w_sum = r_acc + (r_mplier[0] ? r_mcand : '0);

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (i_start) w_next = ST_RUN;
            ST_RUN:  if (w_last)  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_acc      <= '0;
            r_count    <= '0;
            r_sign     <= 1'b0;
            r_result   <= '0;
            r_overflow <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            if (i_start) begin
                r_mcand  <= {{(N-1){1'b0}}, i_multiplicand[c_MSB:0]};
                r_mplier <= i_multiplier[c_MSB:0];
                r_acc    <= '0;
                r_count  <= c_CW'(N - 2);
                r_sign   <= i_multiplicand[c_SB] ^ i_multiplier[c_SB];
            end
        end else begin
            r_acc    <= w_sum;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count - 1'b1;
            if (w_last) begin
                // Sign is kept even for a zero magnitude, matching the divider.
                r_result   <= {r_sign, w_sum[N-2+Q:Q]};
                r_overflow <= |w_sum[c_PW-1:N-1+Q];
            end
        end
    end

    assign o_complete   = (r_state == ST_IDLE);
    assign o_result_out = r_result;
    assign o_overflow   = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_qmult_seq.sv
//------------------------------------------------------------------------------
// Module   : tb_qmult_seq
// Brief    : Scoreboard bench for qmult_seq with a plain-arithmetic reference.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_qmult_seq;

    localparam int Q = 15;
    localparam int N = 32;

    typedef struct {
        logic [N-1:0] res;
        logic         ovf;
    } exp_t;

    logic         i_clk;
    logic         i_rst;
    logic [N-1:0] i_multiplicand;
    logic [N-1:0] i_multiplier;
    logic         i_start;
    logic [N-1:0] o_result_out;
    logic         o_complete;
    logic         o_overflow;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    qmult_seq #(.Q(Q), .N(N)) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_multiplicand (i_multiplicand),
        .i_multiplier   (i_multiplier),
        .i_start        (i_start),
        .o_result_out   (o_result_out),
        .o_complete     (o_complete),
        .o_overflow     (o_overflow)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Exact product of the magnitudes, then truncate to (Q,N).
    function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b);
        exp_t        e;
        longint unsigned ma, mb, p, mag;
        ma    = longint'(a[N-2:0]);
        mb    = longint'(b[N-2:0]);
        p     = ma * mb;
        mag   = (p >> Q) & ((64'd1 << (N-1)) - 64'd1);
        e.res = {a[N-1] ^ b[N-1], mag[N-2:0]};
        e.ovf = (p >> (N-1+Q)) != 64'd0;
        return e;
    endfunction

    // Monitor: pop and compare on each completion; outputs must hold while busy.
    logic         prev_c = 1'b1;
    int           busy   = 0;
    logic [N-1:0] last_res = '0;
    logic         last_ovf = 1'b0;
    always @(negedge i_clk) begin
        exp_t e;
        if (i_rst) begin
            prev_c   = 1'b1;
            busy     = 0;
            last_res = '0;
            last_ovf = 1'b0;
        end else begin
            if (!o_complete) begin
                busy++;
                checks++;
                if (o_result_out !== last_res || o_overflow !== last_ovf) begin
                    errors++;
                    $display("FAIL hold_during_run: got %h/%b need %h/%b", o_result_out, o_overflow, last_res, last_ovf);
                end
            end
            if (o_complete && !prev_c) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_completion: got result %h, need no completion", o_result_out);
                end else begin
                    e = sb.pop_front();
                    checks++;
                    if (o_result_out !== e.res) begin
                        errors++;
                        $display("FAIL result: got %h need %h", o_result_out, e.res);
                    end
                    checks++;
                    if (o_overflow !== e.ovf) begin
                        errors++;
                        $display("FAIL overflow: got %b need %b (result %h)", o_overflow, e.ovf, e.res);
                    end
                    if (busy != N-1) begin
                        errors++;
                        $display("FAIL latency: got %0d busy cycles need %0d", busy, N-1);
                    end
                end
                busy     = 0;
                last_res = o_result_out;
                last_ovf = o_overflow;
            end
            prev_c = o_complete;
        end
    end

    // Called at posedge+1: waits for idle, presents operands, lets one edge load.
    task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, input bit hold);
        int t = 0;
        while (!o_complete && t < 200) begin
            @(posedge i_clk); #1;
            t++;
        end
        if (!o_complete) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: got o_complete=%b need 1", o_complete);
        end
        i_multiplicand = a;
        i_multiplier   = b;
        i_start        = 1'b1;
        sb.push_back(model(a, b));
        @(posedge i_clk); #1;
        if (!hold) i_start = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((sb.size() != 0 || !o_complete) && t < 500) begin
            @(posedge i_clk); #1;
            t++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending need 0", sb.size());
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (o_complete !== 1'b1 || o_result_out !== '0 || o_overflow !== 1'b0) begin
            errors++;
            $display("FAIL %s: got c=%b r=%h o=%b need c=1 r=00000000 o=0", tag, o_complete, o_result_out, o_overflow);
        end
    endtask

    initial begin
        logic [N-1:0] a, b;
        i_rst = 1'b1;
        i_start = 1'b0;
        i_multiplicand = '0;
        i_multiplier = '0;
        repeat (2) @(posedge i_clk);
        #1;
        check_reset_outputs("reset_values");
        i_rst = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        check_reset_outputs("idle_no_start");

        // Directed cases.
        issue(32'h0000C000, 32'h00010000, 0);
        issue(32'h8000C000, 32'h00010000, 0);
        issue(32'h8000C000, 32'h80010000, 0);
        issue(32'h40000000, 32'h00010000, 0);
        issue(32'h00000001, 32'h00004000, 0);
        issue(32'h80000000, 32'h00004000, 0);
        issue(32'h7FFFFFFF, 32'h7FFFFFFF, 0);
        drain();

        // Busy start must be ignored.
        issue(32'h00008000, 32'h00008000, 0);
        repeat (5) @(posedge i_clk);
        #1;
        i_multiplicand = 32'h00030000;
        i_multiplier   = 32'h00050000;
        i_start        = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        drain();
        repeat (40) @(posedge i_clk);
        #1;

        // Back-to-back with start held high.
        for (int i = 0; i < 4; i++) begin
            a = $urandom & 32'h8003FFFF;
            b = $urandom & 32'h8003FFFF;
            issue(a, b, 1);
        end
        i_start = 1'b0;
        drain();

        // Randomized mix of small and full-range operands.
        for (int i = 0; i < 30; i++) begin
            if (i % 3 == 0) begin
                a = $urandom;
                b = $urandom;
            end else begin
                a = $urandom & 32'h800FFFFF;
                b = $urandom & 32'h8001FFFF;
            end
            issue(a, b, 0);
        end
        drain();

        // Abort at RUN cycle 10, then a fresh operation.
        issue(32'h00018000, 32'h00028000, 0);
        repeat (9) @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        #1;
        check_reset_outputs("reset_abort");
        sb.delete();
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        @(posedge i_clk); #1;
        issue(32'h0000C000, 32'h8000C000, 0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish, need finish");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
